// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one execute-stage ALU between two requesters.
//
// State table:
//   IDLE | waiting for a request; ALU drive registers hold their last values
//   EXEC | ALU inputs held stable; cnt counts down the multiply settle window
//   RESP | result/flag presented to the owner until it asserts respN_ready
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/ready/a/b/cmd/op   request handshake and operands, N = 0,1
//   respN_valid/ready/result/flag response handshake and ALU result, N = 0,1
//   alu_in1/alu_in2/alu_cmd/alu_op registered drive to the shared ALU
//   alu_result/alu_flag           ALU outputs, captured at the end of EXEC
//   busy                          high whenever the arbiter is not in IDLE
module alu_arbiter #(
  parameter int MUL_LAT = 3,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [3:0]        req0_cmd,
  input  logic [1:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [3:0]        req1_cmd,
  input  logic [1:0]        req1_op,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_result,
  output logic              resp0_flag,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_result,
  output logic              resp1_flag,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_cmd,
  output logic [1:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_flag,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                prio_q, prio_d;
  logic                owner_q, owner_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   in1_q, in1_d, in2_q, in2_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [1:0]          op_q, op_d;
  logic                rv0_q, rv0_d, rv1_q, rv1_d;
  logic [DATA_W-1:0]   res0_q, res0_d, res1_q, res1_d;
  logic                flg0_q, flg0_d, flg1_q, flg1_d;

  logic                grant0, grant1;
  logic [DATA_W-1:0]   sel_a, sel_b;
  logic [3:0]          sel_cmd;
  logic [1:0]          sel_op;

  // Contention resolves to prio; a lone requester always wins.
  assign grant0 = req0_valid && (!req1_valid || !prio_q);
  assign grant1 = req1_valid && (!req0_valid || prio_q);

  assign req0_ready = (state_q == S_IDLE) && grant0;
  assign req1_ready = (state_q == S_IDLE) && grant1;
  assign busy       = (state_q != S_IDLE);

  assign sel_a   = grant1 ? req1_a   : req0_a;
  assign sel_b   = grant1 ? req1_b   : req0_b;
  assign sel_cmd = grant1 ? req1_cmd : req0_cmd;
  assign sel_op  = grant1 ? req1_op  : req0_op;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    cmd_d   = cmd_q;
    op_d    = op_q;
    rv0_d   = rv0_q;
    rv1_d   = rv1_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    flg0_d  = flg0_q;
    flg1_d  = flg1_q;
    case (state_q)
      S_IDLE: begin
        if (grant0 || grant1) begin
          owner_d = grant1;
          prio_d  = grant0;
          in1_d   = sel_a;
          in2_d   = sel_b;
          cmd_d   = sel_cmd;
          op_d    = sel_op;
          // Only multiply needs extra settle cycles; cnt==0 means capture next edge.
          cnt_d   = (sel_op == 2'd2 && sel_cmd == 4'b1111) ? 4'(MUL_LAT - 1) : 4'd0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (owner_q) begin
            rv1_d  = 1'b1;
            res1_d = alu_result;
            flg1_d = alu_flag;
          end else begin
            rv0_d  = 1'b1;
            res0_d = alu_result;
            flg0_d = alu_flag;
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (owner_q ? resp1_ready : resp0_ready) begin
          rv0_d   = 1'b0;
          rv1_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      cnt_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      cmd_q   <= '0;
      op_q    <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      res0_q  <= '0;
      res1_q  <= '0;
      flg0_q  <= 1'b0;
      flg1_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      cmd_q   <= cmd_d;
      op_q    <= op_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
      flg0_q  <= flg0_d;
      flg1_q  <= flg1_d;
    end
  end

  assign alu_in1      = in1_q;
  assign alu_in2      = in2_q;
  assign alu_cmd      = cmd_q;
  assign alu_op       = op_q;
  assign resp0_valid  = rv0_q;
  assign resp1_valid  = rv1_q;
  assign resp0_result = res0_q;
  assign resp1_result = res1_q;
  assign resp0_flag   = flg0_q;
  assign resp1_flag   = flg1_q;

endmodule
